bcd_bin_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 30 +++
 rtl/bcd_digit_mac.sv | 17 +
 rtl/bcd_bin_seq.sv | 98 +++++++++
 tb/tb_bcd_bin_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential packed-BCD to binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } bcd_state_e;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  // Smallest result width that holds 10^digits - 1 exactly.
  function automatic int unsigned bcd_bin_width(input int unsigned digits);
    logic [63:0]  max_val;
    int unsigned  width;
    max_val = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      max_val = max_val * 64'd10;
    end
    max_val = max_val - 64'd1;
    width   = 1;
    for (int unsigned b = 1; b < 64; b++) begin
      if ((max_val >> b) != 64'd0) begin
        width = b + 1;
      end
    end
    return width;
  endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// Combinational acc*10 + digit step, truncated to BinW bits, with a non-decimal digit flag.
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int unsigned BinW = 14
) (
  input  logic [BinW-1:0] acc_i,
  input  logic [3:0]      digit_i,
  output logic [BinW-1:0] acc_o,
  output logic            digit_err_o
);

  // Shift-add form of *10; the sum wraps naturally at BinW bits.
  assign acc_o       = (acc_i << 3) + (acc_i << 1) + BinW'(digit_i);
  assign digit_err_o = (digit_i > BCD_DIGIT_MAX);

endmodule

// File: rtl/bcd_bin_seq.sv
// Sequential packed-BCD to binary converter: one digit per cycle, MSD first, valid/ready on both sides.
module bcd_bin_seq
  import bcd_pkg::*;
#(
  parameter int unsigned Digits = 4,
  parameter int unsigned BinW   = bcd_bin_width(Digits)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [4*Digits-1:0]   in_bcd_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [BinW-1:0]       out_bin_o,
  output logic                  out_err_o
);

  localparam int unsigned CntW = (Digits > 1) ? $clog2(Digits) : 1;

  bcd_state_e             state_q, state_d;
  logic [4*Digits-1:0]    bcd_q, bcd_d;
  logic [BinW-1:0]        acc_q, acc_d;
  logic                   err_q, err_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  logic [3:0]             digit;
  logic [BinW-1:0]        mac_acc;
  logic                   mac_err;

  assign digit = bcd_q[{cnt_q, 2'b00} +: 4];

  bcd_digit_mac #(
    .BinW(BinW)
  ) u_mac (
    .acc_i      (acc_q),
    .digit_i    (digit),
    .acc_o      (mac_acc),
    .digit_err_o(mac_err)
  );

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    acc_d   = acc_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          bcd_d   = in_bcd_i;
          acc_d   = '0;
          err_d   = 1'b0;
          cnt_d   = CntW'(Digits - 1);
          state_d = StConv;
        end
      end
      StConv: begin
        acc_d = mac_acc;
        err_d = err_q | mac_err;
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      bcd_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Results come straight from registers; handshakes decode from state only.
  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign out_bin_o   = acc_q;
  assign out_err_o   = err_q;

endmodule

// File: tb/tb_bcd_bin_seq.sv
// Self-checking bench for bcd_bin_seq: directed table, corner sequences and random words.
module tb_bcd_bin_seq;

  localparam int unsigned Digits = 4;
  localparam int unsigned BinW   = 14;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [4*Digits-1:0] in_bcd;
  logic                out_valid;
  logic                out_ready;
  logic [BinW-1:0]     out_bin;
  logic                out_err;

  int n_checks;
  int n_fail;

  bcd_bin_seq #(
    .Digits(Digits),
    .BinW  (BinW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_bcd_i   (in_bcd),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_bin_o  (out_bin),
    .out_err_o  (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     bcd;
    logic [BinW-1:0] bin;
    logic            err;
    int              hold;
    bit              toggle;
  } vec_t;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference: decimal value by positional weights, wrapped to the result width.
  function automatic logic [BinW:0] ref_model(input logic [15:0] bcd);
    longint unsigned val;
    longint unsigned w;
    logic            e;
    logic [3:0]      nib;
    val = 0;
    w   = 1;
    e   = 1'b0;
    for (int i = 0; i < Digits; i++) begin
      nib = bcd[i*4 +: 4];
      val = val + longint'(nib) * w;
      w   = w * 10;
      if (nib > 4'd9) e = 1'b1;
    end
    return {e, BinW'(val % (longint'(1) << BinW))};
  endfunction

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while (!in_ready && w < 30) begin
      @(posedge clk); #1;
      w++;
    end
    check({name, ".idle_wait"}, 32'(in_ready), 32'd1);
  endtask

  task automatic convert(input logic [15:0] bcd, input logic [BinW-1:0] exp_bin,
                         input logic exp_err, input int hold, input bit toggle,
                         input string name);
    int lat;
    bit seen;
    out_ready = (hold == 0);
    wait_idle(name);
    in_valid = 1'b1;
    in_bcd   = bcd;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (toggle) begin
        in_valid = 1'($urandom_range(0, 1));
        in_bcd   = 16'($urandom);
      end
      @(posedge clk); #1;
      if (k < Digits) check({name, ".busy_ready"}, 32'(in_ready), 32'd0);
      if (out_valid) begin
        lat  = k;
        seen = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    check({name, ".latency"}, 32'(lat), 32'(Digits));
    if (seen) begin
      check({name, ".bin"}, 32'(out_bin), 32'(exp_bin));
      check({name, ".err"}, 32'(out_err), 32'(exp_err));
      if (hold > 0) begin
        for (int i = 0; i < hold; i++) begin
          if (toggle) begin
            in_valid = 1'b1;
            in_bcd   = 16'($urandom);
          end
          @(posedge clk); #1;
          check({name, ".hold_valid"}, 32'(out_valid), 32'd1);
          check({name, ".hold_bin"}, 32'(out_bin), 32'(exp_bin));
          check({name, ".hold_err"}, 32'(out_err), 32'(exp_err));
          check({name, ".hold_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({name, ".post_ready"}, 32'(in_ready), 32'd1);
      check({name, ".post_valid"}, 32'(out_valid), 32'd0);
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [BinW:0] r;
    logic [15:0]   w;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bcd    = '0;
    out_ready = 1'b0;

    vecs.push_back('{16'h9999, 14'h270F, 1'b0, 0, 1'b0});
    vecs.push_back('{16'h1234, 14'h04D2, 1'b0, 0, 1'b0});
    vecs.push_back('{16'h0000, 14'h0000, 1'b0, 0, 1'b0});
    vecs.push_back('{16'h12A4, 14'h0518, 1'b1, 0, 1'b0});
    vecs.push_back('{16'hF000, 14'h3A98, 1'b1, 0, 1'b0});
    vecs.push_back('{16'h1234, 14'h04D2, 1'b0, 10, 1'b1});
    vecs.push_back('{16'h0987, 14'h03DB, 1'b0, 0, 1'b1});
    vecs.push_back('{16'h0042, 14'h002A, 1'b0, 2, 1'b0});

    #12;
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.out_bin", 32'(out_bin), 32'd0);
    check("reset.out_err", 32'(out_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      convert(vecs[i].bcd, vecs[i].bin, vecs[i].err, vecs[i].hold, vecs[i].toggle,
              $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a conversion.
    wait_idle("rst_mid");
    in_valid = 1'b1;
    in_bcd   = 16'h9999;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid.out_valid", 32'(out_valid), 32'd0);
    check("rst_mid.out_bin", 32'(out_bin), 32'd0);
    check("rst_mid.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    convert(16'h0042, 14'd42, 1'b0, 0, 1'b0, "after_rst");

    // Random words, mostly decimal with the occasional bad nibble.
    for (int n = 0; n < 30; n++) begin
      for (int d = 0; d < Digits; d++) begin
        w[d*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
      end
      r = ref_model(w);
      convert(w, r[BinW-1:0], r[BinW], $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              $sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
